// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding, nibble width
// and the 4-bit add helper used by the nibble datapath.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Returns {carry, sum} of a + b + c for one nibble.
    function automatic logic [NIBBLE_W:0] nibble_add(
        input logic [NIBBLE_W-1:0] a,
        input logic [NIBBLE_W-1:0] b,
        input logic                c
    );
        return {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c};
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// Optional macro NSA_OVF_EN adds the signed-overflow flag ovf_out.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid_in;
    logic             in_ready_out;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             out_valid_out;
    logic             out_ready_in;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
`ifdef NSA_OVF_EN
    logic             ovf_out;

    modport master (
        output in_valid_in, a_in, b_in, c_in, out_ready_in,
        input  in_ready_out, out_valid_out, sum_out, carry_out, ovf_out
    );

    modport slave (
        input  in_valid_in, a_in, b_in, c_in, out_ready_in,
        output in_ready_out, out_valid_out, sum_out, carry_out, ovf_out
    );
`else
    modport master (
        output in_valid_in, a_in, b_in, c_in, out_ready_in,
        input  in_ready_out, out_valid_out, sum_out, carry_out
    );

    modport slave (
        input  in_valid_in, a_in, b_in, c_in, out_ready_in,
        output in_ready_out, out_valid_out, sum_out, carry_out
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_fa4.sv
// Single 4-bit full adder stage shared by every nibble pass.
module full_adder_4
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                carry_o
);

    assign {carry_o, sum_o} = nibble_add(a_i, b_i, c_i);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one full_adder_4 over WIDTH/4 cycles, LSB nibble first.
// Optional macro NSA_OVF_EN adds the signed-overflow output.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16            // multiple of 4, at least 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    nibble_serial_adder_if.slave  bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cy_q, cy_d;
    logic                 cout_q, cout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [NIBBLE_W-1:0]  fa_sum;
    logic                 fa_cout;

`ifdef NSA_OVF_EN
    logic                 a_s_q, a_s_d;
    logic                 b_s_q, b_s_d;
    logic                 ovf_q, ovf_d;
`endif

    full_adder_4 u_fa (
        .a_i     (a_sh_q[NIBBLE_W-1:0]),
        .b_i     (b_sh_q[NIBBLE_W-1:0]),
        .c_i     (cy_q),
        .sum_o   (fa_sum),
        .carry_o (fa_cout)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef NSA_OVF_EN
        a_s_d   = a_s_q;
        b_s_d   = b_s_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_in) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    cy_d    = bus.c_in;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef NSA_OVF_EN
                    a_s_d   = bus.a_in[WIDTH-1];
                    b_s_d   = bus.b_in[WIDTH-1];
`endif
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Nibble sums enter at the MSB end so the first (LSB) nibble lands at bit 0.
                sum_d  = {fa_sum, sum_q[WIDTH-1:NIBBLE_W]};
                a_sh_d = {{NIBBLE_W{1'b0}}, a_sh_q[WIDTH-1:NIBBLE_W]};
                b_sh_d = {{NIBBLE_W{1'b0}}, b_sh_q[WIDTH-1:NIBBLE_W]};
                cy_d   = fa_cout;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = {CNT_W{1'b0}};
                    cout_d  = fa_cout;
`ifdef NSA_OVF_EN
                    ovf_d   = (a_s_q == b_s_q) & (fa_sum[NIBBLE_W-1] != a_s_q);
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.out_ready_in) begin
`ifdef NSA_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register; handshake flags are registered from the next state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    // Operand shifters, carry chain, counter and result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_sh_q <= {WIDTH{1'b0}};
            b_sh_q <= {WIDTH{1'b0}};
            sum_q  <= {WIDTH{1'b0}};
            cy_q   <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            sum_q  <= sum_d;
            cy_q   <= cy_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef NSA_OVF_EN
    // Operand sign capture and overflow flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_s_q <= 1'b0;
            b_s_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            a_s_q <= a_s_d;
            b_s_q <= b_s_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_out = ovf_q;
`endif

    assign bus.in_ready_out  = in_ready_q;
    assign bus.out_valid_out = out_valid_q;
    assign bus.sum_out       = sum_q;
    assign bus.carry_out     = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder (WIDTH=16) against an
// arithmetic reference model. Define NSA_OVF_EN to also check ovf_out.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // One full transaction; caller is positioned just after a rising edge in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input bit toggle);
        logic [W:0] exp;
        int lat;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        bus.a_in = a;
        bus.b_in = b;
        bus.c_in = c;
        bus.in_valid_in  = 1'b1;
        bus.out_ready_in = toggle;
        chk("in_ready_idle", {31'd0, bus.in_ready_out}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid_in = toggle;
        lat = 0;
        while (lat < 20) begin
            if (toggle) begin
                bus.a_in = ~bus.a_in;
                bus.b_in = bus.b_in + 16'h1111;
                bus.c_in = ~bus.c_in;
            end
            @(posedge clk);
            #1;
            lat++;
            chk("in_ready_busy", {31'd0, bus.in_ready_out}, 32'd0);
            if (bus.out_valid_out) break;
        end
        bus.out_ready_in = 1'b0;
        chk("latency", lat, 32'd4);
        chk("sum", {16'd0, bus.sum_out}, {16'd0, exp[W-1:0]});
        chk("carry", {31'd0, bus.carry_out}, {31'd0, exp[W]});
`ifdef NSA_OVF_EN
        chk("ovf", {31'd0, bus.ovf_out}, {31'd0, ref_ovf(a, b, c)});
`endif
        for (int h = 0; h < hold; h++) begin
            bus.in_valid_in = 1'b1;
            bus.a_in = 16'($urandom);
            bus.b_in = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, bus.out_valid_out}, 32'd1);
            chk("hold_ready", {31'd0, bus.in_ready_out}, 32'd0);
            chk("hold_sum", {16'd0, bus.sum_out}, {16'd0, exp[W-1:0]});
            chk("hold_carry", {31'd0, bus.carry_out}, {31'd0, exp[W]});
        end
        bus.in_valid_in  = 1'b0;
        bus.out_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_in = 1'b0;
        chk("release_valid", {31'd0, bus.out_valid_out}, 32'd0);
        chk("release_ready", {31'd0, bus.in_ready_out}, 32'd1);
`ifdef NSA_OVF_EN
        chk("release_ovf", {31'd0, bus.ovf_out}, 32'd0);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus.in_valid_in  = 1'b0;
        bus.out_ready_in = 1'b0;
        bus.a_in = 16'h0000;
        bus.b_in = 16'h0000;
        bus.c_in = 1'b0;
        #12;
        chk("rst_ready", {31'd0, bus.in_ready_out}, 32'd1);
        chk("rst_valid", {31'd0, bus.out_valid_out}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum_out}, 32'd0);
        chk("rst_carry", {31'd0, bus.carry_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 3, 1'b0);
        run_op(16'h8421, 16'h1248, 1'b0, 1, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom));
        end

        // Abort an operation after two nibble passes.
        bus.a_in = 16'hFFFF;
        bus.b_in = 16'h0001;
        bus.c_in = 1'b1;
        bus.in_valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, bus.in_ready_out}, 32'd1);
        chk("abort_valid", {31'd0, bus.out_valid_out}, 32'd0);
        chk("abort_sum", {16'd0, bus.sum_out}, 32'd0);
        chk("abort_carry", {31'd0, bus.carry_out}, 32'd0);
`ifdef NSA_OVF_EN
        chk("abort_ovf", {31'd0, bus.ovf_out}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", {31'd0, bus.out_valid_out}, 32'd0);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
